mips_main_control_fsm: RTL and testbench
========================================

// Module: mips_main_control_fsm
// PURPOSE
//   Multicycle MIPS main control unit: sequences each instruction through FETCH..writeback states and
//   drives datapath strobes/selects. Sits directly upstream of the ALU control decoder: its OpALU output
//   (00 add, 01 sub/branch, 10 R-type funct decode) feeds that block alongside instr funct.
//   Supports R-type, lw, sw, beq, j; memory accesses stall on a ready handshake.
// PARAMETERS
//   OP_RTYPE  6'b000000  R-type opcode
//   OP_LW     6'b100011  load word opcode
//   OP_SW     6'b101011  store word opcode
//   OP_BEQ    6'b000100  branch-equal opcode
//   OP_J      6'b000010  jump opcode
// PORTS
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   opcode       in   6  IR[31:26], valid from DECODE onward
//   mem_ready    in   1  memory completes current read/write this cycle
//   PCWrite      out  1  unconditional PC load
//   PCWriteCond  out  1  PC load if ALU zero
//   IorD         out  1  mem address: 0=PC, 1=ALUOut
//   MemRead      out  1  memory read request
//   MemWrite     out  1  memory write request
//   IRWrite      out  1  instruction register load
//   MemtoReg     out  1  reg write data: 0=ALUOut, 1=MDR
//   RegDst       out  1  dest reg: 0=rt, 1=rd
//   RegWrite     out  1  register file write
//   ALUSrcA      out  1  0=PC, 1=regA
//   ALUSrcB      out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
//   OpALU        out  2  to ALU control: 00 add, 01 sub, 10 funct
//   PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op   out  1  unsupported opcode seen in DECODE
//   instr_done   out  1  one-cycle pulse in final state of each instruction
//   state        out  4  current state (debug)
// BEHAVIOUR
//   - Single 4-bit state register, async reset to FETCH(0). Outputs: Moore from state, except FETCH/MEMRD/
//     MEMWR strobes qualified by mem_ready as noted. Unlisted outputs are 0 in every state.
//   - While rst=1: all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op,
//     instr_done) forced 0; selects 0; state=0. First active edge after release executes FETCH.
//   - 0 FETCH : MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, OpALU=00, PCSource=00; IRWrite=PCWrite=mem_ready.
//               Stay while !mem_ready; ->DECODE when mem_ready.
//   - 1 DECODE: ALUSrcA=0, ALUSrcB=11, OpALU=00. LW/SW->2, RTYPE->6, BEQ->8, J->9,
//               other -> 0 with illegal_op=1 this cycle (no write strobes issued).
//   - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, OpALU=00. LW->3, SW->5 (opcode held stable by IR).
//   - 3 MEMRD : MemRead, IorD=1; stay while !mem_ready; ->4.
//   - 4 MEMWB : RegWrite, MemtoReg=1, RegDst=0, instr_done; ->0.
//   - 5 MEMWR : MemWrite, IorD=1; stay while !mem_ready; ->0; instr_done=mem_ready.
//   - 6 EXEC  : ALUSrcA=1, ALUSrcB=00, OpALU=10; ->7.
//   - 7 ALUWB : RegWrite, MemtoReg=0, RegDst=1, instr_done; ->0.
//   - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond, PCSource=01, instr_done; ->0.
//   - 9 JUMP  : PCWrite, PCSource=10, instr_done; ->0.
//   - Encodings 10-15 unreachable; if entered, next state FETCH, all strobes 0.
//   - Latency (mem_ready tied 1): R 4, lw 5, sw 4, beq 3, j 3 cycles. Each stall cycle adds 1.
//   - Reset mid-instruction: abandon immediately (async), no partial writes after rst rises.
//   - MemRead and MemWrite never high in the same cycle; RegWrite never with MemWrite.
// STRUCTURE
//   - Shared package mips_ctrl_pkg: state encodings (S_FETCH..S_JUMP), opcode constants, OpALU codes
//     (ALUOP_ADD/SUB/FUNCT) and select encodings, reused by the ALU control decoder.
//   - One sub-module: mips_ctrl_outdec (pure combinational state+mem_ready -> control word); this block
//     holds state register and next-state logic.
// TESTING
//   - Reset: rst=1 mid-EXEC -> state=0, all strobes 0 same cycle; release -> FETCH with MemRead=1.
//   - R-type (opcode 0, mem_ready=1): states 0,1,6,7,0; OpALU=10 in EXEC; RegWrite+RegDst=1 in ALUWB.
//   - lw 6'b100011 with mem_ready low 2 cycles in MEMRD: 0,1,2,3,3,3,4; MemtoReg=1, RegWrite in MEMWB.
//   - sw 6'b101011: 0,1,2,5; MemWrite=1, IorD=1; instr_done only on mem_ready cycle; no RegWrite.
//   - beq 6'b000100 -> 0,1,8 with OpALU=01, PCWriteCond=1, PCSource=01; j 6'b000010 -> 9, PCSource=10.
//   - Illegal opcode 6'b111111: DECODE asserts illegal_op 1 cycle, returns to FETCH, no write strobes.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared definitions for the multicycle MIPS control path:
//     - main-control state encodings (S_FETCH .. S_JUMP)
//     - opcode constants for the supported instruction classes
//     - OpALU codes handed to the ALU control decoder
//     - datapath select encodings (ALUSrcB, PCSource, IorD, MemtoReg, ...)
//     - is_legal_op(): true for opcodes this control unit sequences
//   The ALU control decoder imports the same package so that OpALU codes
//   stay in one place.
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Main control states. Encodings 10..15 are unused and treated as
  // illegal by the next-state logic (recover to FETCH).
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // OpALU codes consumed by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // ALU operand A select
  localparam logic SRCA_PC   = 1'b0;
  localparam logic SRCA_REGA = 1'b1;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Memory address select
  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  // Register write data / destination selects
  localparam logic M2R_ALUOUT = 1'b0;
  localparam logic M2R_MDR    = 1'b1;
  localparam logic RDST_RT    = 1'b0;
  localparam logic RDST_RD    = 1'b1;

  // True for the opcodes this control unit knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// ----------------------------------------------------------------------------
// mips_ctrl_outdec
//   Pure combinational control-word decoder for the main control FSM.
//   Outputs are a function of the current state only (Moore), except:
//     - FETCH: IRWrite/PCWrite follow mem_ready (load IR and PC+4 only when
//       the instruction word actually arrives)
//     - MEMWR: instr_done follows mem_ready (store completes that cycle)
//     - DECODE: illegal_op flags an opcode that cannot be sequenced
//   Any state encoding outside S_FETCH..S_JUMP decodes to all zeros.
// Ports
//   state        in   4  current FSM state
//   mem_ready    in   1  memory completes current access this cycle
//   opcode       in   6  IR[31:26]
//   PCWrite .. instr_done  out  datapath control word (see top)
// ----------------------------------------------------------------------------
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] OpALU,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       instr_done
);

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = IORD_PC;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = M2R_ALUOUT;
    RegDst      = RDST_RT;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REGB;
    OpALU       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;

    case (state)
      S_FETCH: begin
        // Read instruction at PC while the ALU computes PC+4.
        MemRead  = 1'b1;
        IorD     = IORD_PC;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_FOUR;
        OpALU    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute the branch target PC + (imm << 2).
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_IMMSH2;
        OpALU      = ALUOP_ADD;
        illegal_op = !is_legal_op(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        OpALU   = ALUOP_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = IORD_ALUOUT;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = M2R_MDR;
        RegDst     = RDST_RT;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = IORD_ALUOUT;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_REGB;
        OpALU   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = M2R_ALUOUT;
        RegDst     = RDST_RD;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // ALU compares A-B; PC takes the target latched in ALUOut on zero.
        ALUSrcA     = SRCA_REGA;
        ALUSrcB     = SRCB_REGB;
        OpALU       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: begin
        // Unused encodings: everything stays at the inactive defaults.
      end
    endcase
  end

endmodule

// File: rtl/mips_main_control_fsm.sv
// ----------------------------------------------------------------------------
// mips_main_control_fsm
//   Multicycle MIPS main control unit. Sequences R-type, lw, sw, beq and j
//   through FETCH..writeback and drives the datapath strobes and selects.
//   OpALU feeds the downstream ALU control decoder together with funct.
//   Memory states (FETCH, MEMRD, MEMWR) hold until mem_ready.
//
//   Structure: state register + next-state logic live here; the output
//   decode is the combinational sub-module mips_ctrl_outdec. While rst is
//   high every output is forced to 0, so nothing is written during reset
//   even though the (reset) state is FETCH.
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   opcode       in   6  IR[31:26], valid from DECODE onward
//   mem_ready    in   1  memory completes current read/write this cycle
//   PCWrite      out  1  unconditional PC load
//   PCWriteCond  out  1  PC load if ALU zero
//   IorD         out  1  memory address: 0=PC, 1=ALUOut
//   MemRead      out  1  memory read request
//   MemWrite     out  1  memory write request
//   IRWrite      out  1  instruction register load
//   MemtoReg     out  1  register write data: 0=ALUOut, 1=MDR
//   RegDst       out  1  destination register: 0=rt, 1=rd
//   RegWrite     out  1  register file write
//   ALUSrcA      out  1  0=PC, 1=regA
//   ALUSrcB      out  2  00=regB, 01=4, 10=signext imm, 11=signext imm<<2
//   OpALU        out  2  00 add, 01 sub, 10 funct decode
//   PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//   illegal_op   out  1  unsupported opcode seen in DECODE
//   instr_done   out  1  pulse in the final state of each instruction
//   state        out  4  current state (debug)
// ----------------------------------------------------------------------------
module mips_main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] OpALU,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Raw decoder outputs before reset gating
  logic       dec_pc_write;
  logic       dec_pc_write_cond;
  logic       dec_iord;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_ir_write;
  logic       dec_mem_to_reg;
  logic       dec_reg_dst;
  logic       dec_reg_write;
  logic       dec_alu_src_a;
  logic [1:0] dec_alu_src_b;
  logic [1:0] dec_op_alu;
  logic [1:0] dec_pc_source;
  logic       dec_illegal_op;
  logic       dec_instr_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;  // illegal: drop it, fetch next
        endcase
      end
      S_MEMADR: begin
        // IR holds the opcode, so it still tells lw from sw here.
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  // Output decode
  mips_ctrl_outdec u_outdec (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .opcode      (opcode),
    .PCWrite     (dec_pc_write),
    .PCWriteCond (dec_pc_write_cond),
    .IorD        (dec_iord),
    .MemRead     (dec_mem_read),
    .MemWrite    (dec_mem_write),
    .IRWrite     (dec_ir_write),
    .MemtoReg    (dec_mem_to_reg),
    .RegDst      (dec_reg_dst),
    .RegWrite    (dec_reg_write),
    .ALUSrcA     (dec_alu_src_a),
    .ALUSrcB     (dec_alu_src_b),
    .OpALU       (dec_op_alu),
    .PCSource    (dec_pc_source),
    .illegal_op  (dec_illegal_op),
    .instr_done  (dec_instr_done)
  );

  // Reset gating: the state register already sits at FETCH during reset,
  // but FETCH would otherwise issue MemRead, so everything is squashed here.
  always_comb begin
    PCWrite     = dec_pc_write      & ~rst;
    PCWriteCond = dec_pc_write_cond & ~rst;
    IorD        = dec_iord          & ~rst;
    MemRead     = dec_mem_read      & ~rst;
    MemWrite    = dec_mem_write     & ~rst;
    IRWrite     = dec_ir_write      & ~rst;
    MemtoReg    = dec_mem_to_reg    & ~rst;
    RegDst      = dec_reg_dst       & ~rst;
    RegWrite    = dec_reg_write     & ~rst;
    ALUSrcA     = dec_alu_src_a     & ~rst;
    ALUSrcB     = dec_alu_src_b     & {2{~rst}};
    OpALU       = dec_op_alu        & {2{~rst}};
    PCSource    = dec_pc_source     & {2{~rst}};
    illegal_op  = dec_illegal_op    & ~rst;
    instr_done  = dec_instr_done    & ~rst;
    state       = state_q;
  end

endmodule

// File: tb/tb_mips_main_control_fsm.sv
module tb_mips_main_control_fsm;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_BAD   = 6'b111111;

  // Compared word: {state[3:0], PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
  // IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], OpALU[1:0],
  // PCSource[1:0], illegal_op, instr_done}
  localparam int W = 22;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, instr_done;
  logic [1:0] ALUSrcB, OpALU, PCSource;
  logic [3:0] state;

  mips_main_control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .OpALU       (OpALU),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .instr_done  (instr_done),
    .state       (state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       r;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;   // expected state during this cycle
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st);
    vec_t v;
    v.r = r; v.op = op; v.mr = mr; v.st = st;
    vecs.push_back(v);
  endtask

  // Expected control word for a given state, written from the state table.
  function automatic logic [W-5:0] model(input logic [3:0] st, input logic mr,
                                         input logic [5:0] op, input logic r);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill, done;
    logic [1:0] srcb, aop, pcs;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
    rdst = 0; rw = 0; srca = 0; ill = 0; done = 0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin
        srcb = 2'b11;
        ill = !(op == T_RTYPE || op == T_LW || op == T_SW || op == T_BEQ || op == T_J);
      end
      4'd2: begin srca = 1; srcb = 2'b10; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; done = 1; end
      4'd5: begin mwr = 1; iord = 1; done = mr; end
      4'd6: begin srca = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rdst = 1; done = 1; end
      4'd8: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd9: begin pcw = 1; pcs = 2'b10; done = 1; end
      default: ;
    endcase
    if (r) return '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill, done};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] actual();
    return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSource,
            illegal_op, instr_done};
  endfunction

  task automatic expect_now(input logic [3:0] st, input logic mr,
                            input logic [5:0] op, input logic r);
    exp_q.push_back({st, model(st, mr, op, r)});
  endtask

  task automatic check(input string name);
    logic [W-1:0] e, a;
    e = exp_q.pop_front();
    a = actual();
    n_vec++;
    if (a !== e || (MemRead && MemWrite) || (RegWrite && MemWrite)) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
               name, a[W-1:W-4], a[W-5:0], e[W-1:W-4], e[W-5:0]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalls;
    // reset
    add(1, T_RTYPE, 1, 0);
    // R-type: 0,1,6,7
    add(0, T_RTYPE, 1, 0); add(0, T_RTYPE, 1, 1);
    add(0, T_RTYPE, 1, 6); add(0, T_RTYPE, 1, 7);
    // lw with 2 stall cycles in MEMRD: 0,1,2,3,3,3,4
    add(0, T_LW, 1, 0); add(0, T_LW, 1, 1); add(0, T_LW, 1, 2);
    add(0, T_LW, 0, 3); add(0, T_LW, 0, 3); add(0, T_LW, 1, 3);
    add(0, T_LW, 1, 4);
    // sw with one stall in MEMWR: 0,1,2,5,5
    add(0, T_SW, 1, 0); add(0, T_SW, 1, 1); add(0, T_SW, 1, 2);
    add(0, T_SW, 0, 5); add(0, T_SW, 1, 5);
    // beq behind a 2-cycle fetch stall
    add(0, T_BEQ, 0, 0); add(0, T_BEQ, 0, 0); add(0, T_BEQ, 1, 0);
    add(0, T_BEQ, 1, 1); add(0, T_BEQ, 1, 8);
    // j
    add(0, T_J, 1, 0); add(0, T_J, 1, 1); add(0, T_J, 1, 9);
    // lw with a random number of MEMRD stalls
    stalls = $urandom_range(1, 4);
    add(0, T_LW, 1, 0); add(0, T_LW, 1, 1); add(0, T_LW, 1, 2);
    for (int k = 0; k < stalls; k++) add(0, T_LW, 0, 3);
    add(0, T_LW, 1, 3); add(0, T_LW, 1, 4);
    // illegal opcode: DECODE flags it, back to FETCH (held there by a stall)
    add(0, T_BAD, 1, 0); add(0, T_BAD, 1, 1); add(0, T_BAD, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r;
      opcode = vecs[i].op;
      mem_ready = vecs[i].mr;
      expect_now(vecs[i].st, vecs[i].mr, vecs[i].op, vecs[i].r);
      #1;
      check($sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of EXEC, between clock edges.
    @(negedge clk);
    opcode = T_RTYPE; mem_ready = 1;
    expect_now(0, 1, T_RTYPE, 0); #1; check("rst_seq_fetch");
    @(negedge clk);
    expect_now(1, 1, T_RTYPE, 0); #1; check("rst_seq_decode");
    @(negedge clk);
    expect_now(6, 1, T_RTYPE, 0); #1; check("rst_seq_exec");
    #2 rst = 1;
    expect_now(0, 1, T_RTYPE, 1); #1; check("rst_async_clear");
    @(negedge clk);
    expect_now(0, 1, T_RTYPE, 1); #1; check("rst_held");
    @(negedge clk);
    rst = 0;
    expect_now(0, 1, T_RTYPE, 0); #1; check("rst_release_fetch");
    @(negedge clk);
    expect_now(1, 1, T_RTYPE, 0); #1; check("rst_release_decode");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
